// File: rtl/sequential_divider_16_bit.sv
// Sequential signed 16-bit divider: one unsigned restoring step per clock
// on operand magnitudes, followed by a sign-fixup cycle. Results truncate
// toward zero and the remainder takes the sign of the dividend.
module sequential_divider_16_bit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] dividend,
  input  logic signed [WIDTH-1:0] divisor,
  output logic signed [WIDTH-1:0] quotient,
  output logic signed [WIDTH-1:0] remainder,
  output logic                    busy,
  output logic                    done,
  output logic                    div_by_zero
);

  localparam int unsigned PR_W  = WIDTH + 1;        // partial remainder width
  localparam int unsigned SH_W  = WIDTH + 2;        // shifted/trial width (keeps borrow bit)
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]        cnt;
  logic [PR_W-1:0]         prem;        // partial remainder
  logic [WIDTH-1:0]        qsh;         // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]        dvs_mag;
  logic                    dvd_neg;
  logic                    dvs_neg;
  logic                    zero_pend;   // divide-by-zero result due on the next edge
  logic signed [WIDTH-1:0] op_dividend;

  logic                    accept_c;
  logic [SH_W-1:0]         shifted_c;
  logic [SH_W-1:0]         trial_c;
  logic                    step_ok_c;

  logic signed [WIDTH-1:0] quotient_d;
  logic signed [WIDTH-1:0] remainder_d;
  logic                    busy_d;
  logic                    done_d;
  logic                    div_by_zero_d;

  assign accept_c = start && ((state == IDLE) || (state == DONE));

  // Restoring step: shift in next dividend bit, trial-subtract |divisor|
  always_comb begin
    shifted_c = {prem, qsh[WIDTH-1]};
    trial_c   = shifted_c - SH_W'(dvs_mag);
    step_ok_c = ~trial_c[SH_W-1];
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a zero divisor bypasses CALC/FIX and completes from DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (divisor == '0) ? DONE : CALC;
        else       state_nxt = IDLE;
      end
      CALC:    if (cnt == LAST_STEP) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; results only move on completion
  always_comb begin
    quotient_d    = quotient;
    remainder_d   = remainder;
    div_by_zero_d = div_by_zero;
    done_d        = 1'b0;
    busy_d        = (state_nxt == CALC) || (state_nxt == FIX);
    if (state == FIX) begin
      quotient_d    = (dvd_neg ^ dvs_neg) ? WIDTH'(-qsh) : qsh;
      remainder_d   = dvd_neg ? WIDTH'(-prem[WIDTH-1:0]) : prem[WIDTH-1:0];
      div_by_zero_d = 1'b0;
      done_d        = 1'b1;
    end
    if (zero_pend) begin
      quotient_d    = '1;
      remainder_d   = op_dividend;
      div_by_zero_d = 1'b1;
      done_d        = 1'b1;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      prem        <= '0;
      qsh         <= '0;
      dvs_mag     <= '0;
      dvd_neg     <= 1'b0;
      dvs_neg     <= 1'b0;
      zero_pend   <= 1'b0;
      op_dividend <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      quotient    <= quotient_d;
      remainder   <= remainder_d;
      busy        <= busy_d;
      done        <= done_d;
      div_by_zero <= div_by_zero_d;
      zero_pend   <= 1'b0;
      if (accept_c) begin
        op_dividend <= dividend;
        dvd_neg     <= dividend[WIDTH-1];
        dvs_neg     <= divisor[WIDTH-1];
        qsh         <= dividend[WIDTH-1] ? WIDTH'(-dividend) : dividend;
        dvs_mag     <= divisor[WIDTH-1] ? WIDTH'(-divisor) : divisor;
        prem        <= '0;
        cnt         <= '0;
        zero_pend   <= (divisor == '0);
      end else if (state == CALC) begin
        prem <= step_ok_c ? trial_c[PR_W-1:0] : shifted_c[PR_W-1:0];
        qsh  <= {qsh[WIDTH-2:0], step_ok_c};
        cnt  <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sequential_divider_16_bit.sv
// Directed bench for the sequential signed divider.
module tb_sequential_divider_16_bit;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic signed [15:0] dividend;
  logic signed [15:0] divisor;
  logic signed [15:0] quotient;
  logic signed [15:0] remainder;
  logic               busy;
  logic               done;
  logic               div_by_zero;

  int checks = 0;
  int errors = 0;

  sequential_divider_16_bit #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Present operands before an edge and hold start across exactly that edge (E0)
  task automatic accept(input logic signed [15:0] a, input logic signed [15:0] b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_div(input logic signed [15:0] a, input logic signed [15:0] b,
                         input logic signed [15:0] eq, input logic signed [15:0] er,
                         input string name);
    int n;
    n = -1;
    accept(a, b);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin n = i; break; end
    end
    checks++;
    if (n !== 17) begin errors++; $display("FAIL %s latency got %0d want 17", name, n); end
    checks++;
    if (quotient !== eq) begin errors++; $display("FAIL %s quotient got %0d want %0d", name, quotient, eq); end
    checks++;
    if (remainder !== er) begin errors++; $display("FAIL %s remainder got %0d want %0d", name, remainder, er); end
    checks++;
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL %s div_by_zero got %b want 0", name, div_by_zero); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s done_pulse got %b want 0", name, done); end
    checks++;
    if (quotient !== eq) begin errors++; $display("FAIL %s quotient_hold got %0d want %0d", name, quotient, eq); end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #3;
    checks++;
    if ({quotient, remainder} !== 32'h0) begin errors++; $display("FAIL reset_results got %h want 0", {quotient, remainder}); end
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, div_by_zero}); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    accept(16'sd25, 16'sd5);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_E0 got %b want 1", busy); end
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, done} !== 2'b10) begin errors++; $display("FAIL basic_busy_E%0d got %b want 10", k, {busy, done}); end
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, done} !== 2'b01) begin errors++; $display("FAIL basic_E17_flags got %b want 01", {busy, done}); end
    checks++;
    if (quotient !== 16'sd5 || remainder !== 16'sd0) begin errors++; $display("FAIL basic_result got %0d/%0d want 5/0", quotient, remainder); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_single got %b want 0", done); end
  endtask

  task automatic test_signs();
    run_div(-16'sd7, 16'sd2, -16'sd3, -16'sd1, "neg_pos");
    run_div(16'sd7, -16'sd2, -16'sd3, 16'sd1, "pos_neg");
    run_div(-16'sd7, -16'sd2, 16'sd3, -16'sd1, "neg_neg");
    run_div(16'sd3, 16'sd7, 16'sd0, 16'sd3, "small");
  endtask

  task automatic test_boundary();
    run_div(16'sh8000, -16'sd1, 16'sh8000, 16'sd0, "min_by_m1");
    run_div(16'sh8000, 16'sd1, -16'sd32768, 16'sd0, "min_by_1");
    run_div(16'sd32767, 16'sd32767, 16'sd1, 16'sd0, "max_by_max");
  endtask

  task automatic test_div_zero();
    accept(16'sd100, 16'sd0);
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL dz_E0_flags got %b want 00", {busy, done}); end
    @(posedge clk); #1;
    checks++;
    if (quotient !== 16'shFFFF || remainder !== 16'sd100) begin errors++; $display("FAIL dz_result got %h/%0d want ffff/100", quotient, remainder); end
    checks++;
    if ({div_by_zero, done, busy} !== 3'b110) begin errors++; $display("FAIL dz_flags got %b want 110", {div_by_zero, done, busy}); end
    run_div(16'sd9, 16'sd3, 16'sd3, 16'sd0, "after_dz");
  endtask

  task automatic test_back_to_back();
    int n;
    accept(16'sd25, 16'sd5);
    for (int k = 1; k <= 17; k++) begin
      if (k == 5) begin
        @(negedge clk);
        start = 1'b1; dividend = 16'sd50; divisor = 16'sd7;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL ignore_done got %b want 1", done); end
    checks++;
    if (quotient !== 16'sd5 || remainder !== 16'sd0) begin errors++; $display("FAIL ignore_result got %0d/%0d want 5/0", quotient, remainder); end
    accept(16'sd50, 16'sd7);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin n = i; break; end
    end
    checks++;
    if (n !== 17) begin errors++; $display("FAIL b2b_latency got %0d want 17", n); end
    checks++;
    if (quotient !== 16'sd7 || remainder !== 16'sd1) begin errors++; $display("FAIL b2b_result got %0d/%0d want 7/1", quotient, remainder); end
  endtask

  task automatic test_mid_reset();
    int seen;
    accept(16'sd25, 16'sd5);
    repeat (8) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    checks++;
    if ({quotient, remainder} !== 32'h0) begin errors++; $display("FAIL mid_reset_results got %h want 0", {quotient, remainder}); end
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL mid_reset_flags got %b want 000", {busy, done, div_by_zero}); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL mid_reset_no_done got %0d want 0", seen); end
    run_div(16'sd25, 16'sd5, 16'sd5, 16'sd0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_boundary();
    test_div_zero();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
